// File: rtl/step_ctrl_pkg.sv
// Shared state encoding and widths for the step_ctrl single-step / free-run controller.
package step_ctrl_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      RUN     = 2'd2
   } state_e;

endpackage

// File: rtl/step_ctrl_debounce.sv
// Two-flop synchronizer plus consecutive-sample debouncer for an active-low pushbutton.
// level_o idles high and only follows the input after DEBOUNCE_CYCLES agreeing samples.
module step_ctrl_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_ni,
   output logic level_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic [CW-1:0] cnt_q;

   // Synchronize, then count consecutive samples that disagree with the held level.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= key_ni;
         sync2_q <= sync1_q;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            level_q <= sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/step_ctrl.sv
// Processor step controller: debounced single-step button or free-running step pulses.
// Define STEP_CTRL_COUNT_EN to build the 16-bit step counter; otherwise step_count reads zero.
module step_ctrl
   import step_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int RUN_DIV         = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               key_n,
   input  logic               run_sw,
   output logic               step_en,
   output logic [15:0]        step_count,
   output logic [STATE_W-1:0] state_o
);

   localparam int DW = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

   logic          level_s;
   logic          level_prev_q;
   logic          press_s;
   logic          release_s;
   state_e        state_q;
   logic [DW-1:0] div_q;
   logic          step_en_q;
`ifdef STEP_CTRL_COUNT_EN
   logic [15:0]   count_q;
`endif

   step_ctrl_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk_i  (clock),
      .rst_ni (reset),
      .key_ni (key_n),
      .level_o(level_s)
   );

   assign press_s   = level_prev_q & ~level_s;
   assign release_s = ~level_prev_q & level_s;

   // Mode FSM; step_en and the counter are updated in the same edge so they stay aligned.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         level_prev_q <= 1'b1;
         state_q      <= IDLE;
         div_q        <= '0;
         step_en_q    <= 1'b0;
`ifdef STEP_CTRL_COUNT_EN
         count_q      <= 16'h0000;
`endif
      end else begin
         level_prev_q <= level_s;
         step_en_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (run_sw) begin
                  state_q <= RUN;
                  div_q   <= '0;
               end else if (press_s) begin
                  state_q   <= PRESSED;
                  step_en_q <= 1'b1;
`ifdef STEP_CTRL_COUNT_EN
                  count_q   <= count_q + 16'd1;
`endif
               end
            end
            PRESSED: begin
               if (release_s) begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               // Leaving RUN wins over a divider terminal count in the same cycle.
               if (!run_sw) begin
                  state_q <= IDLE;
                  div_q   <= '0;
               end else if (div_q == DIV_LAST) begin
                  div_q     <= '0;
                  step_en_q <= 1'b1;
`ifdef STEP_CTRL_COUNT_EN
                  count_q   <= count_q + 16'd1;
`endif
               end else begin
                  div_q <= div_q + DW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               div_q   <= '0;
            end
         endcase
      end
   end

   assign step_en = step_en_q;
   assign state_o = state_q;
`ifdef STEP_CTRL_COUNT_EN
   assign step_count = count_q;
`else
   assign step_count = 16'h0000;
`endif

endmodule
